parity_stream_checker: RTL and testbench

PARITY_STREAM_CHECKER -- requirements
Module: parity_stream_checker

---
 rtl/parity_stream_checker.sv | 101 ++++++++++
 tb/tb_parity_stream_checker.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/parity_stream_checker.sv
// Frame-based parity checker: accepts FRAME_LEN nibbles per frame, counts
// per-nibble parity mismatches (saturating) and accumulates whole-frame parity.
module parity_stream_checker #(
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_valid,
  input  logic [3:0]       i_data,
  input  logic             i_par,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_frame_par
);

  localparam int unsigned      NIB_W    = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [NIB_W-1:0] nib_q, nib_d;
  logic [CNT_W-1:0] err_d;
  logic             par_d;
  logic             ready_d, busy_d, done_d;
  logic             accept_c, data_par_c;

  // Next-state, counters and next registered outputs
  always_comb begin
    state_d    = state_q;
    nib_d      = nib_q;
    err_d      = o_err_cnt;
    par_d      = o_frame_par;
    ready_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    data_par_c = ^i_data;
    accept_c   = i_valid & o_ready & (state_q == RUN);

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = RUN;
          nib_d   = '0;
          err_d   = '0;
          par_d   = 1'b0;
        end
      end
      RUN: begin
        if (accept_c) begin
          par_d = o_frame_par ^ data_par_c;
          if ((data_par_c != i_par) && (o_err_cnt != ERR_MAX)) begin
            err_d = o_err_cnt + CNT_W'(1);
          end
          if (nib_q == LAST_NIB) begin
            state_d = DONE;
          end else begin
            nib_d = nib_q + NIB_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of what the next state implies
    ready_d = (state_d == RUN);
    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      nib_q       <= '0;
      o_err_cnt   <= '0;
      o_frame_par <= 1'b0;
      o_ready     <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      state_q     <= state_d;
      nib_q       <= nib_d;
      o_err_cnt   <= err_d;
      o_frame_par <= par_d;
      o_ready     <= ready_d;
      o_busy      <= busy_d;
      o_done      <= done_d;
    end
  end

endmodule

// File: tb/tb_parity_stream_checker.sv
// Scoreboard bench: frame drivers push expected results; per-DUT monitors
// pop and compare on each o_done pulse.
module tb_parity_stream_checker;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  // Default-parameter DUT
  logic       m_start, m_valid, m_par;
  logic [3:0] m_data;
  logic       m_ready, m_busy, m_done, m_fpar;
  logic [3:0] m_err;

  // Saturation DUT (CNT_W=2, FRAME_LEN=8)
  logic       s_start, s_valid, s_par;
  logic [3:0] s_data;
  logic       s_ready, s_busy, s_done, s_fpar;
  logic [1:0] s_err;

  typedef struct {
    int err;
    int par;
    int cyc;
  } exp_t;

  exp_t q_m[$];
  exp_t q_s[$];

  parity_stream_checker u_main (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(m_start), .i_valid(m_valid),
    .i_data(m_data), .i_par(m_par), .o_ready(m_ready), .o_busy(m_busy),
    .o_done(m_done), .o_err_cnt(m_err), .o_frame_par(m_fpar)
  );

  parity_stream_checker #(.FRAME_LEN(8), .CNT_W(2)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_valid(s_valid),
    .i_data(s_data), .i_par(s_par), .o_ready(s_ready), .o_busy(s_busy),
    .o_done(s_done), .o_err_cnt(s_err), .o_frame_par(s_fpar)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int get_err(input bit sat);
    return sat ? int'(s_err) : int'(m_err);
  endfunction
  function automatic int get_par(input bit sat);
    return sat ? int'(s_fpar) : int'(m_fpar);
  endfunction
  function automatic int get_busy(input bit sat);
    return sat ? int'(s_busy) : int'(m_busy);
  endfunction
  function automatic int get_ready(input bit sat);
    return sat ? int'(s_ready) : int'(m_ready);
  endfunction
  function automatic int get_done(input bit sat);
    return sat ? int'(s_done) : int'(m_done);
  endfunction

  task automatic set_in(input bit sat, input logic s, input logic v,
                        input logic [3:0] d, input logic p);
    if (sat) begin
      s_start = s; s_valid = v; s_data = d; s_par = p;
    end else begin
      m_start = s; m_valid = v; m_data = d; m_par = p;
    end
  endtask

  // Pops one expected result per done pulse and checks pulse width/flags
  task automatic monitor(input bit sat);
    bit   prev = 1'b0;
    exp_t e;
    string tag;
    tag = sat ? "sat" : "main";
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (get_done(sat) == 1) begin
          check({tag, "_done_width"}, int'(prev), 0);
          check({tag, "_done_busy"}, get_busy(sat), 0);
          check({tag, "_done_ready"}, get_ready(sat), 0);
          if (sat) check({tag, "_sb_pending"}, int'(q_s.size() != 0), 1);
          else     check({tag, "_sb_pending"}, int'(q_m.size() != 0), 1);
          if ((sat && q_s.size() != 0) || (!sat && q_m.size() != 0)) begin
            e = sat ? q_s.pop_front() : q_m.pop_front();
            check({tag, "_err_cnt"}, get_err(sat), e.err);
            check({tag, "_frame_par"}, get_par(sat), e.par);
            check({tag, "_done_cycle"}, cyc, e.cyc);
          end
        end
        prev = (get_done(sat) == 1);
      end
    end
  endtask

  initial monitor(1'b0);
  initial monitor(1'b1);

  // Start, stream n nibbles with optional gaps (start pulsed inside gaps), then verify hold
  task automatic send_frame(input bit sat, input logic [3:0] d[8], input logic p[8],
                            input int n, input int gap, input int exp_err, input int exp_par);
    exp_t e;
    @(posedge clk); #1;
    set_in(sat, 1'b1, 1'b0, 4'h0, 1'b0);
    @(posedge clk); #1;
    set_in(sat, 1'b0, 1'b0, 4'h0, 1'b0);
    check("run_busy", get_busy(sat), 1);
    check("run_ready", get_ready(sat), 1);
    for (int i = 0; i < n; i++) begin
      set_in(sat, 1'b0, 1'b1, d[i], p[i]);
      @(posedge clk); #1;
      if (i != n - 1) begin
        for (int g = 0; g < gap; g++) begin
          set_in(sat, (g == 0), 1'b0, 4'hB, 1'b0);
          @(posedge clk); #1;
          check("gap_busy", get_busy(sat), 1);
        end
      end
    end
    set_in(sat, 1'b0, 1'b0, 4'h0, 1'b0);
    e.err = exp_err; e.par = exp_par; e.cyc = cyc;
    if (sat) q_s.push_back(e); else q_m.push_back(e);
    repeat (4) @(posedge clk);
    #1;
    check("hold_err", get_err(sat), exp_err);
    check("hold_par", get_par(sat), exp_par);
    check("idle_busy", get_busy(sat), 0);
    check("idle_done", get_done(sat), 0);
  endtask

  task automatic check_reset_outputs(input bit sat);
    check("rst_ready", get_ready(sat), 0);
    check("rst_busy", get_busy(sat), 0);
    check("rst_done", get_done(sat), 0);
    check("rst_err", get_err(sat), 0);
    check("rst_par", get_par(sat), 0);
  endtask

  initial begin
    logic [3:0] d[8];
    logic       p[8];
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    set_in(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs(1'b0);
    check_reset_outputs(1'b1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Clean frame: parities all match, frame parity = 1
    d = '{4'h0, 4'h1, 4'h3, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    p = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    send_frame(1'b0, d, p, 4, 0, 0, 1);

    // Error frame: three mismatches, frame parity = 0
    d = '{4'h1, 4'h7, 4'h0, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0};
    p = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    send_frame(1'b0, d, p, 4, 0, 3, 0);

    // Gapped clean frame with garbage data and start pulses in the gaps
    d = '{4'h0, 4'h1, 4'h3, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    p = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    send_frame(1'b0, d, p, 4, 2, 0, 1);

    // Saturation: eight mismatching nibbles into a 2-bit counter
    d = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
    p = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    send_frame(1'b1, d, p, 8, 0, 3, 0);

    // Reset mid-frame after two erroneous accepts
    @(posedge clk); #1;
    set_in(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 1'b1, 4'h1, 1'b0);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 1'b1, 4'h7, 1'b0);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    check("pre_rst_err", get_err(1'b0), 2);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs(1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    d = '{4'h0, 4'h1, 4'h3, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    p = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    send_frame(1'b0, d, p, 4, 0, 0, 1);

    repeat (5) @(posedge clk);
    #1;
    check("main_sb_drained", q_m.size(), 0);
    check("sat_sb_drained", q_s.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
